// File: rtl/time_pkg.sv
// Shared constants, FSM encoding and BCD helper for the hh:mm:ss timekeeping core.
package time_pkg;

  // Packed-BCD limits for each field
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HR24_MAX = 8'h23;
  localparam logic [7:0] HR12_MAX = 8'h12;
  localparam logic [7:0] HR12_MIN = 8'h01;

  // Repeat slots swallowed after a button press before auto-repeat starts
  localparam int RPT_HOLDOFF = 5;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  // Two-digit packed-BCD increment without range limiting; the caller handles the wrap.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter with programmable top value and wrap-to value.
// carry is combinational: high in the cycle an increment wraps the counter.
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       inc,
  input  logic       sclr,
  input  logic [7:0] max_val,
  input  logic [7:0] min_val,
  output logic [7:0] q,
  output logic       carry
);

  assign carry = inc & (q == max_val);

  // Synchronous clear wins over increment; increment wraps from max_val to min_val
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      q <= RST_VAL;
    end else if (sclr) begin
      q <= 8'h00;
    end else if (inc) begin
      q <= (q == max_val) ? min_val : bcd_inc(q);
    end
  end

endmodule

// File: rtl/edge_rise.sv
// Two-flop synchronizer plus history flop; flags the rising edge of an async level.
// A level that is already high when reset releases is not reported as an edge:
// the detector only arms after it has seen a genuine synchronized low.
module edge_rise (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic lvl,
  output logic rise
);

  logic s1, s2, hist;
  logic prm1, prm2;
  logic armed;

  // Synchronize, keep one cycle of history, and arm after the chain holds real data that was low
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      hist  <= 1'b0;
      prm1  <= 1'b0;
      prm2  <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1    <= d;
      s2    <= s1;
      hist  <= s2;
      prm1  <= 1'b1;
      prm2  <= prm1;
      armed <= armed | (prm2 & ~s2);
    end
  end

  assign lvl  = s2;
  assign rise = s2 & ~hist & armed;

endmodule

// File: rtl/hms_time_counter.sv
// Timekeeping core: seconds/minutes/hours in packed BCD with RUN/SET modes.
// All state advances on the falling edge of clk.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  ST_RUN | normal counting on 1 Hz rises; buttons ignored
//  ST_SET | sec held at 00; inc_min / inc_hr adjust fields, with auto-repeat
module hms_time_counter
  import time_pkg::*;
#(
  parameter bit         MODE_24H   = 1'b1,
  parameter logic [7:0] RST_HR_BCD = 8'h00,
  parameter bit         AUTO_RPT   = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       sec_wave,
  input  logic       rpt_wave,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic       pm,
  output logic       min_tick,
  output logic       day_tick,
  output logic       setting
);

  localparam logic [2:0] HOLD = 3'(RPT_HOLDOFF);
  localparam logic [7:0] HR_MAX = MODE_24H ? HR24_MAX : HR12_MAX;
  localparam logic [7:0] HR_MIN = MODE_24H ? 8'h00 : HR12_MIN;

  logic sec_lvl, sec_rise;
  logic rpt_lvl, rpt_rise;
  logic set_lvl, set_rise;
  logic min_lvl, min_rise;
  logic hr_lvl,  hr_rise;

  // Only the edges of the waves and the level of set_mode are consumed
  logic unused_lvls;
  assign unused_lvls = sec_lvl ^ rpt_lvl ^ set_rise;

  edge_rise u_er_sec (.clk(clk), .clr(clr), .d(sec_wave), .lvl(sec_lvl), .rise(sec_rise));
  edge_rise u_er_rpt (.clk(clk), .clr(clr), .d(rpt_wave), .lvl(rpt_lvl), .rise(rpt_rise));
  edge_rise u_er_set (.clk(clk), .clr(clr), .d(set_mode), .lvl(set_lvl), .rise(set_rise));
  edge_rise u_er_min (.clk(clk), .clr(clr), .d(inc_min),  .lvl(min_lvl), .rise(min_rise));
  edge_rise u_er_hr  (.clk(clk), .clr(clr), .d(inc_hr),   .lvl(hr_lvl),  .rise(hr_rise));

  state_t state, state_nxt;
  logic   run, in_set, entering_set;

  // State register
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: follow the synchronized set_mode level
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (set_lvl)  state_nxt = ST_SET;
      ST_SET:  if (!set_lvl) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  assign run          = (state == ST_RUN);
  assign in_set       = (state == ST_SET);
  assign entering_set = run & set_lvl;
  assign setting      = in_set;

  // Auto-repeat hold-off: down-counters reloaded on press, counting repeat slots while held
  logic [2:0] min_hold, hr_hold;
  logic       min_rpt_ok, hr_rpt_ok;

  assign min_rpt_ok = AUTO_RPT & min_lvl & rpt_rise & (min_hold == 3'd0);
  assign hr_rpt_ok  = AUTO_RPT & hr_lvl  & rpt_rise & (hr_hold  == 3'd0);

  // Minute-button hold-off counter
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      min_hold <= HOLD;
    end else if (!in_set || !min_lvl || min_rise) begin
      min_hold <= HOLD;
    end else if (rpt_rise && (min_hold != 3'd0)) begin
      min_hold <= min_hold - 3'd1;
    end
  end

  // Hour-button hold-off counter
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      hr_hold <= HOLD;
    end else if (!in_set || !hr_lvl || hr_rise) begin
      hr_hold <= HOLD;
    end else if (rpt_rise && (hr_hold != 3'd0)) begin
      hr_hold <= hr_hold - 3'd1;
    end
  end

  logic sec_inc, sec_carry;
  logic min_inc, min_carry;
  logic hr_inc,  hr_carry;
  logic hr_run_inc;

  // A second edge coinciding with SET entry is dropped
  assign sec_inc    = run & ~set_lvl & sec_rise;
  assign min_inc    = sec_carry | (in_set & (min_rise | min_rpt_ok));
  assign hr_run_inc = run & min_carry;
  assign hr_inc     = hr_run_inc | (in_set & (hr_rise | hr_rpt_ok));

  bcd_mod_counter #(.RST_VAL(8'h00)) u_sec (
    .clk(clk), .clr(clr), .inc(sec_inc), .sclr(entering_set | in_set),
    .max_val(SEC_MAX), .min_val(8'h00), .q(sec_bcd), .carry(sec_carry)
  );

  bcd_mod_counter #(.RST_VAL(8'h00)) u_min (
    .clk(clk), .clr(clr), .inc(min_inc), .sclr(1'b0),
    .max_val(MIN_MAX), .min_val(8'h00), .q(min_bcd), .carry(min_carry)
  );

  bcd_mod_counter #(.RST_VAL(RST_HR_BCD)) u_hr (
    .clk(clk), .clr(clr), .inc(hr_inc), .sclr(1'b0),
    .max_val(HR_MAX), .min_val(HR_MIN), .q(hr_bcd), .carry(hr_carry)
  );

  // pm flips on 11 -> 12 in either state; held at 0 in 24h mode
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      pm <= 1'b0;
    end else if (!MODE_24H && hr_inc && (hr_bcd == 8'h11)) begin
      pm <= ~pm;
    end
  end

  // Rollover pulses, registered so they line up with the updated counters
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      min_tick <= 1'b0;
      day_tick <= 1'b0;
    end else begin
      min_tick <= sec_carry;
      if (MODE_24H) begin
        day_tick <= hr_run_inc & hr_carry;
      end else begin
        day_tick <= hr_run_inc & (hr_bcd == 8'h11) & pm;
      end
    end
  end

endmodule

// File: tb/tb_hms_time_counter.sv
// Directed bench for hms_time_counter: a 24h instance and a 12h instance share stimulus.
module tb_hms_time_counter;

  localparam int OP_CLR    = 0;
  localparam int OP_SEC    = 1;
  localparam int OP_MIN    = 2;
  localparam int OP_HR     = 3;
  localparam int OP_SETON  = 4;
  localparam int OP_SETOFF = 5;

  typedef struct {
    int         dut;
    int         op;
    int         n;
    logic [7:0] sec;
    logic [7:0] mn;
    logic [7:0] hr;
    logic       pm;
    logic       st;
    int         mt;
    int         dt;
  } vec_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic sec_wave = 1'b0, rpt_wave = 1'b0, set_mode = 1'b0, inc_min = 1'b0, inc_hr = 1'b0;

  logic [7:0] a_sec, a_min, a_hr, b_sec, b_min, b_hr;
  logic       a_pm, a_mt, a_dt, a_set, b_pm, b_mt, b_dt, b_set;

  int tests = 0;
  int fails = 0;
  int a_mt_cnt = 0, a_dt_cnt = 0, b_mt_cnt = 0, b_dt_cnt = 0;
  int a_mt_base = 0, a_dt_base = 0, b_mt_base = 0, b_dt_base = 0;

  vec_t vq24[$];
  vec_t vq12[$];

  always #5 clk = ~clk;

  hms_time_counter #(.MODE_24H(1'b1), .RST_HR_BCD(8'h00), .AUTO_RPT(1'b1)) u24 (
    .clk(clk), .clr(clr), .sec_wave(sec_wave), .rpt_wave(rpt_wave), .set_mode(set_mode),
    .inc_min(inc_min), .inc_hr(inc_hr), .sec_bcd(a_sec), .min_bcd(a_min), .hr_bcd(a_hr),
    .pm(a_pm), .min_tick(a_mt), .day_tick(a_dt), .setting(a_set)
  );

  hms_time_counter #(.MODE_24H(1'b0), .RST_HR_BCD(8'h12), .AUTO_RPT(1'b1)) u12 (
    .clk(clk), .clr(clr), .sec_wave(sec_wave), .rpt_wave(rpt_wave), .set_mode(set_mode),
    .inc_min(inc_min), .inc_hr(inc_hr), .sec_bcd(b_sec), .min_bcd(b_min), .hr_bcd(b_hr),
    .pm(b_pm), .min_tick(b_mt), .day_tick(b_dt), .setting(b_set)
  );

  // Count tick pulses mid-cycle, away from the falling active edge
  always @(posedge clk) begin
    if (a_mt) a_mt_cnt <= a_mt_cnt + 1;
    if (a_dt) a_dt_cnt <= a_dt_cnt + 1;
    if (b_mt) b_mt_cnt <= b_mt_cnt + 1;
    if (b_dt) b_dt_cnt <= b_dt_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic samp();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_clr();
    samp();
    clr = 1'b1;
    sec_wave = 1'b0; rpt_wave = 1'b0; set_mode = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
    repeat (2) @(negedge clk);
    samp();
    clr = 1'b0;
    a_mt_base = a_mt_cnt; a_dt_base = a_dt_cnt;
    b_mt_base = b_mt_cnt; b_dt_base = b_dt_cnt;
    repeat (4) @(negedge clk);
  endtask

  task automatic drive(input int op, input logic v);
    case (op)
      OP_SEC: sec_wave = v;
      OP_MIN: inc_min  = v;
      OP_HR:  inc_hr   = v;
      default: rpt_wave = v;
    endcase
  endtask

  task automatic pulse(input int op);
    samp();
    drive(op, 1'b1);
    repeat (4) @(negedge clk);
    samp();
    drive(op, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_op(input int op, input int n);
    case (op)
      OP_CLR: apply_clr();
      OP_SETON, OP_SETOFF: begin
        samp();
        set_mode = (op == OP_SETON);
        repeat (4) @(negedge clk);
      end
      default: repeat (n) pulse(op);
    endcase
  endtask

  task automatic add(input int dut, input int op, input int n, input logic [7:0] s,
                     input logic [7:0] m, input logic [7:0] h, input logic p,
                     input logic st, input int mt, input int dt);
    vec_t v;
    v.dut = dut; v.op = op; v.n = n; v.sec = s; v.mn = m; v.hr = h;
    v.pm = p; v.st = st; v.mt = mt; v.dt = dt;
    if (dut == 0) vq24.push_back(v);
    else vq12.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic [41:0] act, exp;
    do_op(v.op, v.n);
    samp();
    if (v.dut == 0)
      act = {a_sec, a_min, a_hr, a_pm, a_set, 8'(a_mt_cnt - a_mt_base), 8'(a_dt_cnt - a_dt_base)};
    else
      act = {b_sec, b_min, b_hr, b_pm, b_set, 8'(b_mt_cnt - b_mt_base), 8'(b_dt_cnt - b_dt_base)};
    exp = {v.sec, v.mn, v.hr, v.pm, v.st, 8'(v.mt), 8'(v.dt)};
    check(name, 64'(act), 64'(exp));
  endtask

  logic [7:0] rpt_exp [8];

  initial begin
    // 24h table: fields are sec, min, hr, pm, setting, min_ticks, day_ticks
    add(0, OP_CLR,     0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, OP_SEC,     1, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, OP_SEC,     8, 8'h09, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, OP_SEC,     1, 8'h10, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, OP_SEC,    49, 8'h59, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, OP_SEC,     1, 8'h00, 8'h01, 8'h00, 0, 0, 1, 0);
    add(0, OP_SEC,     5, 8'h05, 8'h01, 8'h00, 0, 0, 1, 0);
    add(0, OP_SETON,   0, 8'h00, 8'h01, 8'h00, 0, 1, 1, 0);
    add(0, OP_MIN,    57, 8'h00, 8'h58, 8'h00, 0, 1, 1, 0);
    add(0, OP_SEC,     2, 8'h00, 8'h58, 8'h00, 0, 1, 1, 0);
    add(0, OP_MIN,     1, 8'h00, 8'h59, 8'h00, 0, 1, 1, 0);
    add(0, OP_MIN,     1, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0);
    add(0, OP_MIN,     1, 8'h00, 8'h01, 8'h00, 0, 1, 1, 0);
    add(0, OP_MIN,    58, 8'h00, 8'h59, 8'h00, 0, 1, 1, 0);
    add(0, OP_HR,     23, 8'h00, 8'h59, 8'h23, 0, 1, 1, 0);
    add(0, OP_SETOFF,  0, 8'h00, 8'h59, 8'h23, 0, 0, 1, 0);
    add(0, OP_SEC,    58, 8'h58, 8'h59, 8'h23, 0, 0, 1, 0);
    // 12h table
    add(1, OP_CLR,     0, 8'h00, 8'h00, 8'h12, 0, 0, 0, 0);
    add(1, OP_SETON,   0, 8'h00, 8'h00, 8'h12, 0, 1, 0, 0);
    add(1, OP_HR,     11, 8'h00, 8'h00, 8'h11, 0, 1, 0, 0);
    add(1, OP_MIN,    59, 8'h00, 8'h59, 8'h11, 0, 1, 0, 0);
    add(1, OP_SETOFF,  0, 8'h00, 8'h59, 8'h11, 0, 0, 0, 0);
    add(1, OP_SEC,    59, 8'h59, 8'h59, 8'h11, 0, 0, 0, 0);
    add(1, OP_SEC,     1, 8'h00, 8'h00, 8'h12, 1, 0, 1, 0);
    add(1, OP_SETON,   0, 8'h00, 8'h00, 8'h12, 1, 1, 1, 0);
    add(1, OP_HR,      1, 8'h00, 8'h00, 8'h01, 1, 1, 1, 0);
    add(1, OP_HR,     10, 8'h00, 8'h00, 8'h11, 1, 1, 1, 0);
    add(1, OP_HR,      1, 8'h00, 8'h00, 8'h12, 0, 1, 1, 0);
    add(1, OP_HR,     12, 8'h00, 8'h00, 8'h12, 1, 1, 1, 0);
    add(1, OP_HR,     11, 8'h00, 8'h00, 8'h11, 1, 1, 1, 0);
    add(1, OP_MIN,    59, 8'h00, 8'h59, 8'h11, 1, 1, 1, 0);
    add(1, OP_SETOFF,  0, 8'h00, 8'h59, 8'h11, 1, 0, 1, 0);
    add(1, OP_SEC,    59, 8'h59, 8'h59, 8'h11, 1, 0, 1, 0);
    add(1, OP_SEC,     1, 8'h00, 8'h00, 8'h12, 0, 0, 2, 1);

    // Asynchronous clear mid-count, then release with sec_wave already high
    apply_clr();
    repeat (37) pulse(OP_SEC);
    samp();
    check("pre_clr_sec", 64'(a_sec), 64'h37);
    @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    check("clr_async_24", 64'({a_sec, a_min, a_hr, a_pm, a_mt, a_dt, a_set}), 64'h0);
    check("clr_async_12", 64'({b_sec, b_min, b_hr, b_pm, b_mt, b_dt, b_set}), 64'({8'h00, 8'h00, 8'h12, 4'h0}));
    sec_wave = 1'b1;
    repeat (2) @(negedge clk);
    samp();
    clr = 1'b0;
    repeat (6) @(negedge clk);
    samp();
    check("rel_high_no_edge", 64'(a_sec), 64'h00);
    sec_wave = 1'b0;
    repeat (4) @(negedge clk);
    samp();
    sec_wave = 1'b1;
    repeat (4) @(negedge clk);
    samp();
    sec_wave = 1'b0;
    repeat (4) @(negedge clk);
    samp();
    check("rel_one_inc", 64'(a_sec), 64'h01);

    // 24h table, ending at 23:59:58
    for (int i = 0; i < vq24.size(); i++) run_vec(vq24[i], $sformatf("v24_%0d", i));

    // 23:59:58 -> 23:59:59 -> 00:00:00 with single-cycle ticks
    pulse(OP_SEC);
    samp();
    check("wrap_59", 64'({a_sec, a_min, a_hr, a_mt, a_dt}), 64'({8'h59, 8'h59, 8'h23, 2'b00}));
    sec_wave = 1'b1;
    repeat (3) @(negedge clk);
    samp();
    check("wrap_day", 64'({a_sec, a_min, a_hr, a_mt, a_dt}), 64'({8'h00, 8'h00, 8'h00, 2'b11}));
    @(negedge clk);
    samp();
    check("wrap_tick_end", 64'({a_mt, a_dt}), 64'(2'b00));
    sec_wave = 1'b0;
    repeat (4) @(negedge clk);
    samp();
    check("wrap_tick_cnt", 64'({8'(a_mt_cnt - a_mt_base), 8'(a_dt_cnt - a_dt_base)}), 64'h0201);

    // 12h table
    for (int i = 0; i < vq12.size(); i++) run_vec(vq12[i], $sformatf("v12_%0d", i));

    // Auto-repeat on held inc_hr from 20
    rpt_exp = '{8'h21, 8'h21, 8'h21, 8'h21, 8'h21, 8'h22, 8'h23, 8'h00};
    apply_clr();
    do_op(OP_SETON, 0);
    repeat (20) pulse(OP_HR);
    samp();
    check("rpt_start", 64'(a_hr), 64'h20);
    inc_hr = 1'b1;
    repeat (4) @(negedge clk);
    samp();
    check("rpt_press", 64'(a_hr), 64'h21);
    for (int k = 0; k < 8; k++) begin
      samp();
      rpt_wave = 1'b1;
      repeat (4) @(negedge clk);
      samp();
      rpt_wave = 1'b0;
      repeat (4) @(negedge clk);
      samp();
      check($sformatf("rpt_%0d", k + 1), 64'(a_hr), 64'(rpt_exp[k]));
    end
    inc_hr = 1'b0;
    repeat (4) @(negedge clk);
    samp();
    check("rpt_no_day", 64'({a_set, 8'(a_dt_cnt - a_dt_base)}), 64'({1'b1, 8'h00}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hms_time_counter.md
Name: hms_time_counter

Overview:
- Timekeeping core of the digital clock.
- Consumes the square-wave outputs of the clock-divider stage: the 1 Hz wave and the 10 Hz wave.
- Counts seconds, minutes and hours in packed BCD, and supports a set mode for adjusting hours and minutes.
- Outputs feed the display multiplexer / seven-segment decode stage directly.

Parameters:
- MODE_24H, 1: 1 = hours 00..23; 0 = hours 01..12 with pm flag.
- RST_HR_BCD, 8'h00: hour value loaded on reset; must be legal for MODE_24H (8'h12 when MODE_24H=0).
- AUTO_RPT, 1: 1 = a held inc button repeats at the 10 Hz rate while in SET.

Ports:
- clk  in  1  system clock; all sequential logic runs on the falling edge.
- clr  in  1  reset, asynchronous, active-high.
- sec_wave  in  1  1 Hz square wave from the divider; its rising edge = one second.
- rpt_wave  in  1  10 Hz square wave from the divider; its rising edge = one repeat slot.
- set_mode  in  1  level: 1 = SET state requested.
- inc_min  in  1  debounced button level: increment minutes.
- inc_hr  in  1  debounced button level: increment hours.
- sec_bcd  out  8  seconds, {tens,units}, 00..59.
- min_bcd  out  8  minutes, 00..59.
- hr_bcd  out  8  hours, 00..23 or 01..12.
- pm  out  1  12h mode: 1 = PM. Constant 0 when MODE_24H=1.
- min_tick  out  1  one-clk pulse on each seconds 59->00 rollover.
- day_tick  out  1  one-clk pulse on each day rollover (23:59:59->00:00:00, or 11:59:59 PM->12:00:00 AM).
- setting  out  1  1 while in SET state.

Behaviour:
- Reset (clr high, asynchronous):
  - sec=00, min=00, hr=RST_HR_BCD, pm=0; all pulse outputs 0; state RUN.
  - All edge-detect history registers load 0, so a wave that is high at reset release produces no spurious edge.
- Edge detect:
  - Each async-origin input (sec_wave, rpt_wave, set_mode, inc_min, inc_hr) passes through a 2-flop synchronizer, then a history flop.
  - Rise = sync & ~hist. Latency from input edge to counter update: 3 falling clk edges.
- FSM, two states:
  - RUN -> SET when the synced set_mode is 1.
    - On entry: sec is cleared to 00 in the same cycle.
    - Any pending second edge in that cycle is dropped.
  - SET -> RUN when the synced set_mode is 0.
    - Counting resumes from the next sec rise; no catch-up.
- RUN state:
  - On each sec rise: sec+1.
  - At 59: sec -> 00, min+1, min_tick=1.
  - At min 59 with a sec carry: min -> 00, hr+1.
  - Hour wrap, 24h: 23 -> 00, with day_tick.
  - Hour wrap, 12h:
    - 12 -> 01.
    - 11 -> 12 toggles pm.
    - day_tick fires on 11 PM -> 12 AM.
  - inc_min and inc_hr are ignored.
- SET state:
  - sec is held at 00; sec edges are ignored.
  - inc_min rise: min+1, wraps 59 -> 00, no carry into hr.
  - inc_hr rise: hr+1 using the normal hour wrap including the pm toggle; no day_tick.
  - Both rises in the same cycle: both apply independently.
  - With AUTO_RPT=1, if a button stays high, each rpt_wave rise after the first 5 rpt rises following the press applies one further increment (≈0.5 s delay, then 10/s).
  - min_tick and day_tick stay 0.
- BCD rules:
  - Units digit wraps 9 -> 0 with carry to tens.
  - Tens limit: 5 for sec/min; for hr the 2-digit compare is applied on the full 8 bits.
  - Non-BCD values never occur. They are not checked.
- Pulses: min_tick and day_tick are high for exactly one clk, registered, aligned with the updated counters.
- Reset mid-count or mid-SET: immediate return to reset values; no partial update survives.

Decomposition:
- Shared package time_pkg holds:
  - BCD limit constants SEC_MAX=8'h59, MIN_MAX=8'h59, HR24_MAX=8'h23, HR12_MAX=8'h12, HR12_MIN=8'h01.
  - FSM state encoding ST_RUN and ST_SET.
  - Constant RPT_HOLDOFF=5.
- Sub-module bcd_mod_counter: 8-bit BCD counter with inc, programmable max/min-on-wrap, and a carry-out.
  - Instantiated three times (sec, min, hr).
  - The hr instance gets wrap values selected by MODE_24H.
- Synchronizer + edge detector is a small shared sub-module, edge_rise, instantiated five times.

Test Plan:
- clr pulse mid-count (sec=8'h37) -> sec/min=00, hr=RST_HR_BCD, pm=0, all pulses 0 on the same cycle, without a clk edge.
- RUN, preload 23:59:58 (MODE_24H=1), two sec_wave rises -> 23:59:59 then 00:00:00; min_tick and day_tick each 1 for exactly one clk on the second update.
- MODE_24H=0, preload 11:59:59 pm=0, one sec rise -> 12:00:00 pm=1, no day_tick. Repeat from 11:59:59 pm=1 -> 12:00:00 pm=0, day_tick=1.
- set_mode=1 at sec=8'h42 -> sec=00 and setting=1 after 3 clks. Three inc_min rises from min=58 -> 59, 00, 01 with hr unchanged. sec_wave rises ignored.
- SET, AUTO_RPT=1, hold inc_hr from hr=20 across 8 rpt_wave rises -> hr sequence 21 (press), then 22, 23, 00 on rpt rises 6, 7, 8; no day_tick.
- sec_wave high during clr release, then low, then high -> exactly one increment (sec=01), not two.
